// File: rtl/gray_sched.sv
// gray_sched: round-robin scheduler that lends one shared 3-bit gray
// counter to two requesters. A granted job clears the counter, steps it
// Steps times, then captures the final count and overflow flag.
module gray_sched (
   input  logic       Clk,
   input  logic       Reset,
   input  logic [1:0] Req,
   input  logic [3:0] Steps0,
   input  logic [3:0] Steps1,
   input  logic [2:0] CntOut,
   input  logic       CntOvf,
   output logic       CntEn,
   output logic       CntReset,
   output logic [1:0] Grant,
   output logic       Busy,
   output logic [1:0] Done,
   output logic [2:0] Result,
   output logic       OvfSeen
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CLR  = 2'd1,
      RUN  = 2'd2,
      FIN  = 2'd3
   } state_t;

   state_t     state;
   state_t     state_nxt;

   logic       owner;      // current job owner, 0 or 1
   logic       last;       // owner of the most recently completed job
   logic [3:0] remaining;  // enabled counter edges still owed to the job
   logic [1:0] done_q;
   logic [2:0] result_q;
   logic       ovf_q;

   logic       pick;       // arbitration winner for this IDLE cycle
   logic       start;      // IDLE cycle that accepts a request
   logic       cnt_en;
   logic       cnt_clr;

   // Round-robin pick: a lone request wins outright; on a tie the
   // requester that did not finish last goes first.
   always_comb begin
      pick = 1'b0;
      case (Req)
         2'b01:   pick = 1'b0;
         2'b10:   pick = 1'b1;
         2'b11:   pick = ~last;
         default: pick = 1'b0;
      endcase
   end

   assign start = (state == IDLE) && (Req != 2'b00);

   // State register.
   always_ff @(posedge Clk) begin
      if (Reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // Next-state and counter controls.
   always_comb begin
      state_nxt = state;
      cnt_en    = 1'b0;
      cnt_clr   = 1'b0;
      case (state)
         IDLE: begin
            if (Req != 2'b00) state_nxt = CLR;
         end
         CLR: begin
            cnt_clr   = 1'b1;
            state_nxt = (remaining != 4'd0) ? RUN : FIN;
         end
         RUN: begin
            cnt_en = 1'b1;
            // remaining==0 cannot occur here; treat it as finished anyway.
            if (remaining <= 4'd1) state_nxt = FIN;
         end
         FIN: begin
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Job bookkeeping: latch owner/steps at grant, count down in RUN,
   // publish the result and a one-cycle Done pulse on the way out of FIN.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         owner     <= 1'b0;
         last      <= 1'b1;
         remaining <= 4'd0;
         done_q    <= 2'b00;
         result_q  <= 3'b000;
         ovf_q     <= 1'b0;
      end else begin
         done_q <= 2'b00;
         if (start) begin
            owner     <= pick;
            remaining <= pick ? Steps1 : Steps0;
         end
         if (state == RUN && remaining != 4'd0)
            remaining <= remaining - 4'd1;
         if (state == FIN) begin
            result_q <= CntOut;
            ovf_q    <= CntOvf;
            last     <= owner;
            done_q   <= owner ? 2'b10 : 2'b01;
         end
      end
   end

   assign Busy     = (state != IDLE);
   assign Grant    = Busy ? (owner ? 2'b10 : 2'b01) : 2'b00;
   assign CntEn    = cnt_en;
   // The counter is held clear for as long as the scheduler is in reset.
   assign CntReset = cnt_clr | Reset;
   assign Done     = done_q;
   assign Result   = result_q;
   assign OvfSeen  = ovf_q;

endmodule

// File: tb/tb_gray_sched.sv
// tb_gray_sched: directed bench for gray_sched with a behavioral model of
// the shared 3-bit gray counter (sticky overflow, cleared by CntReset).
module tb_gray_sched;

   logic       Clk = 1'b0;
   logic       Reset;
   logic [1:0] Req;
   logic [3:0] Steps0, Steps1;
   logic [2:0] CntOut;
   logic       CntOvf;
   logic       CntEn, CntReset, Busy, OvfSeen;
   logic [1:0] Grant, Done;
   logic [2:0] Result;

   int tests = 0;
   int fails = 0;

   gray_sched dut (
      .Clk(Clk), .Reset(Reset), .Req(Req), .Steps0(Steps0), .Steps1(Steps1),
      .CntOut(CntOut), .CntOvf(CntOvf), .CntEn(CntEn), .CntReset(CntReset),
      .Grant(Grant), .Busy(Busy), .Done(Done), .Result(Result), .OvfSeen(OvfSeen)
   );

   always #5 Clk = ~Clk;

   // Shared counter model: binary count, gray-coded output.
   logic [2:0] bin;
   logic       ovf;
   always_ff @(posedge Clk) begin
      if (CntReset) begin
         bin <= 3'd0;
         ovf <= 1'b0;
      end else if (CntEn) begin
         if (bin == 3'd7) ovf <= 1'b1;
         bin <= bin + 3'd1;
      end
   end
   assign CntOut = bin ^ (bin >> 1);
   assign CntOvf = ovf;

   // Drives one request and measures the job up to its Done pulse.
   // lat is counted in cycles from the sampling IDLE cycle; -1 on timeout.
   task automatic run_job(input logic [1:0] req, input logic [3:0] s0, s1,
                          input int chg_at, input logic [3:0] s_chg,
                          output int lat, output int gcyc, output int ecyc,
                          output logic [1:0] gfirst, output logic crfirst,
                          output logic [1:0] dval, output logic [2:0] res,
                          output logic ov, output logic bad);
      lat = -1; gcyc = 0; ecyc = 0; gfirst = 2'b00; crfirst = 1'b0;
      dval = 2'b00; res = 3'b000; ov = 1'b0; bad = 1'b0;
      @(negedge Clk);
      Req = req; Steps0 = s0; Steps1 = s1;
      for (int k = 1; k <= 40; k++) begin
         @(negedge Clk);
         if (k == 1) begin
            gfirst  = Grant;
            crfirst = CntReset;
            Req     = 2'b00;
         end
         if (k == chg_at) begin
            Steps0 = s_chg; Steps1 = s_chg;
         end
         if (Grant != 2'b00) gcyc++;
         if (CntEn) ecyc++;
         if (Grant == 2'b11 || Busy != (Grant != 2'b00)) bad = 1'b1;
         if (Done != 2'b00) begin
            lat = k; dval = Done; res = Result; ov = OvfSeen;
            break;
         end
      end
   endtask

   task automatic do_reset();
      @(negedge Clk);
      Reset = 1'b1; Req = 2'b00;
      @(negedge Clk);
      @(negedge Clk);
      Reset = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge Clk);
      Reset = 1'b1; Req = 2'b11; Steps0 = 4'd3; Steps1 = 4'd3;
      @(negedge Clk);
      @(negedge Clk);
      tests++;
      if ({Grant, Busy, Done, CntEn, CntReset, Result, OvfSeen} !== 11'b00_0_00_0_1_000_0) begin
         fails++;
         $display("FAIL reset_outputs: got G=%b B=%b D=%b E=%b CR=%b R=%b O=%b want 00 0 00 0 1 000 0",
                  Grant, Busy, Done, CntEn, CntReset, Result, OvfSeen);
      end
      Req = 2'b00;
      Reset = 1'b0;
      @(negedge Clk);
      tests++;
      if (CntReset !== 1'b0 || Busy !== 1'b0) begin
         fails++;
         $display("FAIL reset_release: CntReset=%b Busy=%b want 0 0", CntReset, Busy);
      end
   endtask

   // Req=01, Steps0=5: 7 grant cycles, 5 enables, Result=111.
   task automatic test_single();
      int lat, gc, ec; logic [1:0] gf, dv; logic cr, ov, bad; logic [2:0] r;
      run_job(2'b01, 4'd5, 4'd0, 0, 4'd0, lat, gc, ec, gf, cr, dv, r, ov, bad);
      tests++;
      if (lat !== 8 || gc !== 7 || ec !== 5 || gf !== 2'b01 || cr !== 1'b1 || bad) begin
         fails++;
         $display("FAIL single_timing: lat=%0d gcyc=%0d en=%0d gfirst=%b clr=%b bad=%b want 8 7 5 01 1 0",
                  lat, gc, ec, gf, cr, bad);
      end
      tests++;
      if (dv !== 2'b01 || r !== 3'b111 || ov !== 1'b0) begin
         fails++;
         $display("FAIL single_result: done=%b res=%b ovf=%b want 01 111 0", dv, r, ov);
      end
      @(negedge Clk);
      tests++;
      if (Done !== 2'b00 || Result !== 3'b111) begin
         fails++;
         $display("FAIL done_one_cycle: done=%b res=%b want 00 111", Done, Result);
      end
   endtask

   // Overflow on 8 steps, then cleared by CLR of the next job.
   task automatic test_overflow();
      int lat, gc, ec; logic [1:0] gf, dv; logic cr, ov, bad; logic [2:0] r;
      run_job(2'b10, 4'd0, 4'd8, 0, 4'd0, lat, gc, ec, gf, cr, dv, r, ov, bad);
      tests++;
      if (lat !== 11 || gf !== 2'b10 || dv !== 2'b10 || r !== 3'b000 || ov !== 1'b1 || ec !== 8) begin
         fails++;
         $display("FAIL ovf_job: lat=%0d g=%b done=%b res=%b ovf=%b en=%0d want 11 10 10 000 1 8",
                  lat, gf, dv, r, ov, ec);
      end
      repeat (3) @(negedge Clk);
      tests++;
      if (Result !== 3'b000 || OvfSeen !== 1'b1) begin
         fails++;
         $display("FAIL result_hold: res=%b ovf=%b want 000 1", Result, OvfSeen);
      end
      run_job(2'b01, 4'd7, 4'd0, 0, 4'd0, lat, gc, ec, gf, cr, dv, r, ov, bad);
      tests++;
      if (lat !== 10 || dv !== 2'b01 || r !== 3'b100 || ov !== 1'b0) begin
         fails++;
         $display("FAIL ovf_cleared: lat=%0d done=%b res=%b ovf=%b want 10 01 100 0", lat, dv, r, ov);
      end
   endtask

   // Steps=0: CLR then FIN, no enables, Done 3 cycles after sampling.
   task automatic test_zero_steps();
      int lat, gc, ec; logic [1:0] gf, dv; logic cr, ov, bad; logic [2:0] r;
      run_job(2'b01, 4'd0, 4'd0, 0, 4'd0, lat, gc, ec, gf, cr, dv, r, ov, bad);
      tests++;
      if (lat !== 3 || gc !== 2 || ec !== 0 || cr !== 1'b1 || dv !== 2'b01 || r !== 3'b000) begin
         fails++;
         $display("FAIL zero_steps: lat=%0d gcyc=%0d en=%0d clr=%b done=%b res=%b want 3 2 0 1 01 000",
                  lat, gc, ec, cr, dv, r);
      end
   endtask

   // Req dropped after grant and Steps changed mid-job: job unaffected.
   task automatic test_req_drop();
      int lat, gc, ec; logic [1:0] gf, dv; logic cr, ov, bad; logic [2:0] r;
      run_job(2'b01, 4'd3, 4'd0, 2, 4'd15, lat, gc, ec, gf, cr, dv, r, ov, bad);
      tests++;
      if (lat !== 6 || ec !== 3 || dv !== 2'b01 || r !== 3'b010 || bad) begin
         fails++;
         $display("FAIL req_drop: lat=%0d en=%0d done=%b res=%b bad=%b want 6 3 01 010 0",
                  lat, ec, dv, r, bad);
      end
   endtask

   // Reset in RUN with Remaining=3 aborts the job and clears the result.
   task automatic test_reset_mid();
      int lat, gc, ec; logic [1:0] gf, dv; logic cr, ov, bad; logic [2:0] r;
      logic saw_done;
      @(negedge Clk);
      Req = 2'b01; Steps0 = 4'd6;
      for (int k = 1; k <= 5; k++) begin
         @(negedge Clk);
         if (k == 1) Req = 2'b00;
      end
      tests++;
      if (CntEn !== 1'b1 || Grant !== 2'b01) begin
         fails++;
         $display("FAIL mid_in_run: CntEn=%b Grant=%b want 1 01", CntEn, Grant);
      end
      Reset = 1'b1;
      @(negedge Clk);
      tests++;
      if ({Busy, CntEn, Done, Result, OvfSeen, Grant, CntReset} !== 10'b0_0_00_000_0_00_1) begin
         fails++;
         $display("FAIL mid_abort: B=%b E=%b D=%b R=%b O=%b G=%b CR=%b want 0 0 00 000 0 00 1",
                  Busy, CntEn, Done, Result, OvfSeen, Grant, CntReset);
      end
      Reset = 1'b0;
      saw_done = 1'b0;
      repeat (4) begin
         @(negedge Clk);
         if (Done !== 2'b00 || Busy !== 1'b0) saw_done = 1'b1;
      end
      tests++;
      if (saw_done) begin
         fails++;
         $display("FAIL mid_no_done: activity after abort got 1 want 0");
      end
      run_job(2'b01, 4'd1, 4'd0, 0, 4'd0, lat, gc, ec, gf, cr, dv, r, ov, bad);
      tests++;
      if (lat !== 4 || cr !== 1'b1 || gf !== 2'b01 || dv !== 2'b01 || r !== 3'b001) begin
         fails++;
         $display("FAIL mid_restart: lat=%0d clr=%b g=%b done=%b res=%b want 4 1 01 01 001",
                  lat, cr, gf, dv, r);
      end
   endtask

   // Req=11 held after reset: grants alternate 01,10,01 back to back.
   task automatic test_back_to_back();
      logic [1:0] gseq [4];
      logic [1:0] dseq [4];
      int gk [4];
      int dk [4];
      int ng, nd;
      logic [1:0] prev_g;
      logic bad;
      do_reset();
      ng = 0; nd = 0; prev_g = 2'b00; bad = 1'b0;
      for (int i = 0; i < 4; i++) begin gseq[i] = 2'b00; dseq[i] = 2'b00; gk[i] = 0; dk[i] = 0; end
      Steps0 = 4'd2; Steps1 = 4'd2; Req = 2'b11;
      for (int k = 1; k <= 60; k++) begin
         @(negedge Clk);
         if (Grant == 2'b11) bad = 1'b1;
         if (Grant != 2'b00 && prev_g == 2'b00 && ng < 4) begin
            gseq[ng] = Grant; gk[ng] = k; ng++;
         end
         prev_g = Grant;
         if (Done != 2'b00 && nd < 4) begin
            dseq[nd] = Done; dk[nd] = k; nd++;
            if (nd == 3) begin
               Req = 2'b00;
               break;
            end
         end
      end
      Req = 2'b00;
      tests++;
      if (ng !== 3 || nd !== 3 || bad || gseq[0] !== 2'b01 || gseq[1] !== 2'b10 || gseq[2] !== 2'b01) begin
         fails++;
         $display("FAIL rr_grants: ng=%0d nd=%0d bad=%b seq=%b,%b,%b want 3 3 0 01,10,01",
                  ng, nd, bad, gseq[0], gseq[1], gseq[2]);
      end
      tests++;
      if (dseq[0] !== 2'b01 || dseq[1] !== 2'b10 || dseq[2] !== 2'b01) begin
         fails++;
         $display("FAIL rr_done: seq=%b,%b,%b want 01,10,01", dseq[0], dseq[1], dseq[2]);
      end
      tests++;
      if (gk[1] !== dk[0] + 1 || gk[2] !== dk[1] + 1) begin
         fails++;
         $display("FAIL back_to_back: grant cycles %0d,%0d done cycles %0d,%0d want grant=done+1",
                  gk[1], gk[2], dk[0], dk[1]);
      end
      repeat (3) @(negedge Clk);
      tests++;
      if (Busy !== 1'b0 || Result !== 3'b011) begin
         fails++;
         $display("FAIL rr_idle: Busy=%b res=%b want 0 011", Busy, Result);
      end
   endtask

   initial begin
      Reset = 1'b1; Req = 2'b00; Steps0 = 4'd0; Steps1 = 4'd0;
      test_reset();
      test_single();
      test_overflow();
      test_zero_steps();
      test_req_drop();
      test_reset_mid();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/gray_sched.md
GRAY_SCHED -- requirements
Module: gray_sched

Interface
REQ-001 The block SHALL use reset Reset, synchronous, active-high; clock Clk.
REQ-002 Clk  input  1  system clock; all state changes on posedge.
REQ-003 Reset  input  1  synchronous active-high reset.
REQ-004 Req  input  2  per-requester job request, bit i = requester i.
REQ-005 Steps0  input  4  step count for requester 0, sampled at grant.
REQ-006 Steps1  input  4  step count for requester 1, sampled at grant.
REQ-007 CntOut  input  3  Output of the shared gray counter.
REQ-008 CntOvf  input  1  Overflow of the shared gray counter.
REQ-009 CntEn  output  1  En to the shared gray counter.
REQ-010 CntReset  output  1  Reset to the shared gray counter.
REQ-011 Grant  output  2  one-hot owner of the counter; 00 when idle.
REQ-012 Busy  output  1  high whenever state is not IDLE.
REQ-013 Done  output  2  one-cycle completion pulse, bit i = requester i.
REQ-014 Result  output  3  final CntOut of the last completed job.
REQ-015 OvfSeen  output  1  CntOvf at the end of the last completed job.

Function
REQ-016 The FSM SHALL have four states: IDLE, CLR, RUN and FIN.
REQ-017 IDLE SHALL sample Req each cycle; if any bit is set, it SHALL latch the owner and its Steps into Remaining[3:0] and go to CLR.
REQ-018 Arbitration SHALL be round-robin: on Req=11 the grant goes to the requester that is not Last; Last SHALL reset to 1, so requester 0 wins first.
REQ-019 CLR SHALL assert CntReset for exactly one cycle, then go to RUN if Remaining!=0, else to FIN.
REQ-020 RUN SHALL assert CntEn every cycle and decrement Remaining; the cycle in which Remaining==1 SHALL be the last RUN cycle, followed by FIN.
REQ-021 The counter SHALL therefore receive exactly Steps enabled edges (0..15) per job.
REQ-022 FIN SHALL last one cycle; on the edge leaving FIN, Result<=CntOut, OvfSeen<=CntOvf, Last<=owner and Done[owner]<=1, then the FSM returns to IDLE.
REQ-023 Done SHALL be registered: high only in the first IDLE cycle after FIN, with Result and OvfSeen already valid.
REQ-024 Result and OvfSeen SHALL hold until the next job completes.
REQ-025 Grant SHALL be one-hot to the owner in CLR, RUN and FIN, and 00 in IDLE; Busy SHALL equal (Grant!=00).
REQ-026 Req changes after grant SHALL be ignored; a job always runs to completion, and Steps changes mid-job have no effect.
REQ-027 A new grant MAY occur in the same IDLE cycle in which Done pulses, giving back-to-back jobs.
REQ-028 Latency SHALL be N+3 cycles from the IDLE cycle that samples Req to the Done pulse, for Steps=N.
REQ-029 CntEn SHALL be 0 outside RUN; CntReset SHALL be 0 outside CLR, except during Reset.

Reset
REQ-030 While Reset is high, the block SHALL set state to IDLE, Grant=00, Busy=0, Done=00, CntEn=0, Result=000, OvfSeen=0, Remaining=0 and Last=1.
REQ-031 CntReset SHALL be asserted while Reset is high.
REQ-032 Reset mid-job SHALL abort the job with no Done pulse, and Result and OvfSeen SHALL return to 0.

Verification
V1 Req=01, Steps0=5 -> Grant=01 for 7 cycles; CntEn high 5 cycles; Done=01 with Result=111, OvfSeen=0.
V2 Req=10, Steps1=8 -> Result=000, OvfSeen=1; Req=01, Steps0=7 -> Result=100, OvfSeen=0 (overflow cleared by CLR).
V3 Req=11 held after reset -> grants alternate 01, 10, 01; each Done pulses once per job; Grant never 11.
V4 Steps0=0, Req=01 -> CLR then FIN, CntEn never high, Result=000, Done 3 cycles after the sampling cycle.
V5 Reset asserted in RUN with Remaining=3 -> next cycle Busy=0, CntEn=0, Done=00, Result=000; the next request restarts from CLR.
V6 Req=01 dropped one cycle after grant, Steps0=3 -> job still completes, Result=010, Done=01.
